fetch_tagged: RTL and testbench

Next-generation instruction fetch stage between the core-bus instruction port and decode. It streams word-aligned fetches into an L0 buffer and keeps up to `MAX_OT_TXN` reads outstanding. A flush does not wait for in-flight reads to drain: stale replies are counted and discarded while new-PC reads issue the next cycle. Each instruction is delivered with its PC, and an access fault is delivered in program order at the head of the buffer with the faulting PC.

---
 rtl/utils_pkg.sv | 56 +++++
 rtl/fifo.sv | 58 +++++
 rtl/fetch_tagged.sv | 155 +++++++++++++++
 tb/tb_fetch_tagged.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// Shared core-bus, trap and fetch-stage types.
// Imported by the fetch stage and its L0 buffer.
package utils_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] instr_raw_t;
    typedef logic        valid_t;
    typedef logic        ready_t;

    typedef enum logic [1:0] {
        CB_BYTE = 2'd0,
        CB_HALF = 2'd1,
        CB_WORD = 2'd2
    } cb_size_t;

    typedef enum logic [1:0] {
        CB_OKAY   = 2'd0,
        CB_EXOKAY = 2'd1,
        CB_SLVERR = 2'd2,
        CB_DECERR = 2'd3
    } cb_resp_t;

    typedef struct packed {
        logic [31:0] rd_addr;
        cb_size_t    rd_size;
        logic        rd_addr_valid;
        logic        rd_ready;
    } s_cb_mosi_t;

    typedef struct packed {
        logic        rd_addr_ready;
        logic [31:0] rd_data;
        cb_resp_t    rd_resp;
        logic        rd_valid;
    } s_cb_miso_t;

    typedef struct packed {
        logic active;
        pc_t  pc_addr;
    } s_trap_info_t;

    typedef enum logic [1:0] {
        FT_IDLE = 2'd0,
        FT_RUN  = 2'd1,
        FT_HALT = 2'd2
    } fetch_tagged_fsm_t;

    typedef struct packed {
        logic       fault;
        pc_t        pc;
        instr_raw_t instr;
    } s_l0_entry_t;

    localparam pc_t PC_STEP = 32'd4;

endpackage

// File: rtl/fifo.sv
// Circular FIFO with synchronous clear; clear outranks push and pop.
// Head is presented combinationally from the read pointer.
module fifo #(
    parameter int SLOTS = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(SLOTS+1)-1:0] count
);

    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW = $clog2(SLOTS + 1);

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (32'(p) == SLOTS - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (32'(count) == SLOTS);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_tagged.sv
// Instruction fetch stage: credit-limited word reads into an L0 buffer,
// flush-without-drain via a discard counter, in-order fault delivery.
module fetch_tagged
    import utils_pkg::*;
#(
    parameter int L0_BUFFER_SIZE = 4,
    parameter int MAX_OT_TXN     = 4
) (
    input  logic         clk,
    input  logic         rst,
    output s_cb_mosi_t   instr_cb_mosi_o,
    input  s_cb_miso_t   instr_cb_miso_i,
    input  logic         fetch_start_i,
    input  pc_t          fetch_start_addr_i,
    input  logic         fetch_req_i,
    input  pc_t          fetch_addr_i,
    output valid_t       fetch_valid_o,
    input  ready_t       fetch_ready_i,
    output instr_raw_t   fetch_instr_o,
    output pc_t          fetch_pc_o,
    output logic         instr_access_fault_o,
    output s_trap_info_t trap_info_o
);

    localparam int OTW = $clog2(MAX_OT_TXN) + 1;
    localparam int CW  = $clog2(L0_BUFFER_SIZE + 1);

    fetch_tagged_fsm_t state, state_nx;

    logic           start_q;
    logic           req_q;
    logic           start_edge;
    logic           req_edge;
    logic           flush;
    pc_t            target;
    pc_t            req_pc;
    pc_t            resp_pc;
    logic [OTW-1:0] ot_cnt;
    logic [OTW-1:0] discard_cnt;
    logic [CW-1:0]  occ;
    logic           issue;
    logic           sent;
    logic           recv;
    logic           drop;
    logic           write;
    logic           misalign;
    logic           empty;
    logic           full;
    logic           pop;
    s_l0_entry_t    wr_entry;
    s_l0_entry_t    head;

    assign start_edge = fetch_start_i && !start_q;
    assign req_edge   = fetch_req_i && !req_q;
    assign flush      = start_edge || req_edge;
    assign target     = start_edge ? fetch_start_addr_i
                                   : {fetch_addr_i[31:2], 2'b00};
    assign misalign   = fetch_req_i && (fetch_addr_i[1:0] != 2'b00);

    // Credits count in-flight reads that will land, not the discarded ones.
    assign issue = (state == FT_RUN) && !flush
                && (32'(ot_cnt) < 32'(MAX_OT_TXN))
                && (32'(occ) + 32'(ot_cnt - discard_cnt)
                    < 32'(L0_BUFFER_SIZE));

    assign sent  = issue && instr_cb_miso_i.rd_addr_ready;
    assign recv  = instr_cb_miso_i.rd_valid && (ot_cnt != '0);
    assign drop  = recv && (flush || discard_cnt != '0);
    assign write = recv && !drop;

    assign wr_entry.fault = (instr_cb_miso_i.rd_resp != CB_OKAY);
    assign wr_entry.pc    = resp_pc;
    assign wr_entry.instr = instr_cb_miso_i.rd_data;

    always_comb begin
        instr_cb_mosi_o          = '0;
        instr_cb_mosi_o.rd_ready = !rst;
        if (issue) begin
            instr_cb_mosi_o.rd_addr_valid = 1'b1;
            instr_cb_mosi_o.rd_size       = CB_WORD;
            instr_cb_mosi_o.rd_addr       = req_pc;
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = FT_RUN;
        end else if (write && wr_entry.fault) begin
            state_nx = FT_HALT;
        end
    end

    assign fetch_valid_o        = !empty && !flush && !head.fault;
    assign fetch_instr_o        = fetch_valid_o ? head.instr : '0;
    assign fetch_pc_o           = fetch_valid_o ? head.pc : '0;
    assign instr_access_fault_o = !empty && head.fault;
    assign pop                  = fetch_valid_o && fetch_ready_i;

    always_comb begin
        trap_info_o = '0;
        if (misalign) begin
            trap_info_o.active  = 1'b1;
            trap_info_o.pc_addr = fetch_addr_i;
        end else if (instr_access_fault_o) begin
            trap_info_o.active  = 1'b1;
            trap_info_o.pc_addr = head.pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FT_IDLE;
            start_q     <= 1'b0;
            req_q       <= 1'b0;
            req_pc      <= '0;
            resp_pc     <= '0;
            ot_cnt      <= '0;
            discard_cnt <= '0;
        end else begin
            state   <= state_nx;
            start_q <= fetch_start_i;
            req_q   <= fetch_req_i;
            ot_cnt  <= ot_cnt + OTW'(sent) - OTW'(recv);
            if (flush) begin
                req_pc      <= target;
                resp_pc     <= target;
                discard_cnt <= ot_cnt - OTW'(recv);
            end else begin
                if (sent)  req_pc  <= req_pc + PC_STEP;
                if (write) resp_pc <= resp_pc + PC_STEP;
                if (drop && discard_cnt != '0) begin
                    discard_cnt <= discard_cnt - 1'b1;
                end
            end
        end
    end

    fifo #(
        .SLOTS(L0_BUFFER_SIZE),
        .WIDTH($bits(s_l0_entry_t))
    ) u_l0 (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .push     (write),
        .push_data(wr_entry),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .full     (full),
        .count    (occ)
    );

endmodule

// File: tb/tb_fetch_tagged.sv
// Bench for fetch_tagged: in-order bus slave model, PC-stream reference,
// directed corner cases and a randomized flush/back-pressure run.
module tb_fetch_tagged;
    import utils_pkg::*;

    localparam int L0 = 4;
    localparam int OT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    s_cb_mosi_t   mosi;
    s_cb_miso_t   miso = '0;
    logic         start = 1'b0;
    pc_t          start_addr = '0;
    logic         req = 1'b0;
    pc_t          addr = '0;
    logic         valid;
    logic         ready = 1'b1;
    instr_raw_t   instr;
    pc_t          pc;
    logic         fault;
    s_trap_info_t trap;

    always #5 clk = ~clk;

    fetch_tagged #(
        .L0_BUFFER_SIZE(L0),
        .MAX_OT_TXN    (OT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_cb_mosi_o     (mosi),
        .instr_cb_miso_i     (miso),
        .fetch_start_i       (start),
        .fetch_start_addr_i  (start_addr),
        .fetch_req_i         (req),
        .fetch_addr_i        (addr),
        .fetch_valid_o       (valid),
        .fetch_ready_i       (ready),
        .fetch_instr_o       (instr),
        .fetch_pc_o          (pc),
        .instr_access_fault_o(fault),
        .trap_info_o         (trap)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Bus slave model: in-order replies with per-request latency.
    typedef struct {
        pc_t a;
        bit  f;
        int  due;
    } rq_t;

    rq_t  q[$];
    int   cyc = 0;
    int   lat_min = 0;
    int   lat_max = 0;
    int   ardy_pct = 100;
    int   accept_cap = -1;
    int   accepted = 0;
    pc_t  fault_addr = '1;
    bit   rand_faults = 0;

    // Reference stream state.
    bit   mon_on = 0;
    bit   flush_now = 0;
    pc_t  exp_pc = '0;
    pc_t  exp_req = '0;
    int   n_deliv = 0;
    bit   first_seen = 0;
    pc_t  first_pc = '0;

    function automatic bit is_fault(input pc_t a);
        return (a == fault_addr) || (rand_faults && a[6:2] == 5'h1b);
    endfunction

    function automatic instr_raw_t fdata(input pc_t a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
    endfunction

    always @(negedge clk) begin
        rq_t r;
        bit  acc;
        cyc++;
        miso.rd_valid = 1'b0;
        miso.rd_data  = '0;
        miso.rd_resp  = CB_OKAY;
        if (q.size() > 0 && q[0].due <= cyc) begin
            r = q.pop_front();
            miso.rd_valid = 1'b1;
            miso.rd_data  = fdata(r.a);
            miso.rd_resp  = r.f ? CB_SLVERR : CB_OKAY;
        end
        miso.rd_addr_ready = ($urandom_range(0, 99) < ardy_pct)
            && (accept_cap < 0 || accepted < accept_cap);
        acc = !rst && mosi.rd_addr_valid && miso.rd_addr_ready;
        if (acc) begin
            r.a   = mosi.rd_addr;
            r.f   = is_fault(mosi.rd_addr);
            r.due = cyc + int'($urandom_range(lat_min, lat_max));
            q.push_back(r);
            accepted++;
        end
        if (!rst && mon_on) begin
            if (flush_now) begin
                chk("flush_no_issue", mosi.rd_addr_valid, 0);
                chk("flush_no_valid", valid, 0);
            end
            if (acc) begin
                chk("req_addr", mosi.rd_addr, exp_req);
                chk("req_size", mosi.rd_size, CB_WORD);
                exp_req += 4;
            end
            if (valid && ready) begin
                chk("deliv_pc", pc, exp_pc);
                chk("deliv_instr", instr, fdata(exp_pc));
                chk("deliv_not_fault", is_fault(exp_pc), 0);
                if (!first_seen) begin
                    first_seen = 1;
                    first_pc   = pc;
                end
                exp_pc += 4;
                n_deliv++;
            end
            if (!flush_now && fault) begin
                chk("fault_expected", is_fault(exp_pc), 1);
                chk("fault_trap_act", trap.active, 1);
                chk("fault_trap_pc", trap.pc_addr, exp_pc);
                chk("fault_no_valid", valid, 0);
            end
            if (miso.rd_valid) chk("rd_ready", mosi.rd_ready, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        flush_now = 0;
    endtask

    task automatic reset_dut();
        rst   = 1'b1;
        start = 1'b0;
        req   = 1'b0;
        ready = 1'b1;
        q.delete();
        accepted   = 0;
        accept_cap = -1;
        fault_addr = '1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic raise_start(input pc_t a);
        start      = 1'b1;
        start_addr = a;
        flush_now  = 1;
        exp_pc     = a;
        exp_req    = a;
        first_seen = 0;
        tick();
    endtask

    task automatic raise_req(input pc_t a);
        req        = 1'b1;
        addr       = a;
        flush_now  = 1;
        exp_pc     = {a[31:2], 2'b00};
        exp_req    = {a[31:2], 2'b00};
        first_seen = 0;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_deliv(input string nm, input int n, input int budget);
        int goal;
        goal = n_deliv + n;
        for (int i = 0; i < budget && n_deliv < goal; i++) tick();
        chk(nm, 32'(n_deliv >= goal), 1);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_mosi"}, 32'(mosi != '0), 0);
        chk({nm, "_valid"}, valid, 0);
        chk({nm, "_instr"}, instr, 0);
        chk({nm, "_pc"}, pc, 0);
        chk({nm, "_fault"}, fault, 0);
        chk({nm, "_trap"}, 32'(trap != '0), 0);
    endtask

    typedef struct {
        logic r;
        pc_t  a;
        logic act;
        pc_t  tpc;
    } mv_t;

    initial begin
        mv_t tv[5];
        int  d0;
        tv[0] = '{1'b1, 32'h0000_0102, 1'b1, 32'h0000_0102};
        tv[1] = '{1'b1, 32'h0000_0101, 1'b1, 32'h0000_0101};
        tv[2] = '{1'b0, 32'h0000_0102, 1'b0, 32'h0000_0000};
        tv[3] = '{1'b1, 32'h0000_0103, 1'b1, 32'h0000_0103};
        tv[4] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000};

        #1;
        chk_reset("rst0");
        reset_dut();
        chk("rd_ready_out_of_reset", mosi.rd_ready, 1);

        // Misalign trap is combinational on the request level.
        for (int i = 0; i < 5; i++) begin
            req  = tv[i].r;
            addr = tv[i].a;
            #1;
            chk($sformatf("mis_act_%0d", i), trap.active, tv[i].act);
            chk($sformatf("mis_pc_%0d", i), trap.pc_addr, tv[i].tpc);
            tick();
            req = 1'b0;
            repeat (2) tick();
        end

        // Boot from start edge, zero-wait memory.
        reset_dut();
        mon_on = 1;
        raise_start(32'h8000_0000);
        chk("boot_req_valid", mosi.rd_addr_valid, 1);
        chk("boot_req_addr", mosi.rd_addr, 32'h8000_0000);
        repeat (4) tick();
        d0 = n_deliv;
        repeat (30) tick();
        chk("boot_throughput", n_deliv - d0, 30);

        // Redirect with three reads in flight.
        reset_dut();
        lat_min    = 20;
        lat_max    = 20;
        accept_cap = 3;
        raise_start(32'h0);
        repeat (9) tick();
        chk("ot3_before_flush", q.size(), 3);
        lat_min    = 0;
        lat_max    = 0;
        accept_cap = -1;
        raise_req(32'h100);
        chk("flush_req_valid", mosi.rd_addr_valid, 1);
        chk("flush_req_addr", mosi.rd_addr, 32'h100);
        wait_deliv("flush_deliv", 5, 80);
        chk("flush_first_pc", first_pc, 32'h100);

        // Decode stalled: issue stops at the credit limit.
        reset_dut();
        ready = 1'b0;
        raise_start(32'h200);
        repeat (20) tick();
        chk("bp_accepted", accepted, L0);
        chk("bp_valid", valid, 1);
        chk("bp_head_pc", pc, 32'h200);
        chk("bp_rd_ready", mosi.rd_ready, 1);
        chk("bp_no_issue", mosi.rd_addr_valid, 0);
        ready = 1'b1;
        wait_deliv("bp_deliv", 12, 40);

        // Access fault on 0x8, held until a redirect.
        reset_dut();
        fault_addr = 32'h8;
        d0 = n_deliv;
        raise_start(32'h0);
        for (int i = 0; i < 40 && !fault; i++) tick();
        chk("fault_seen", fault, 1);
        chk("fault_pc", trap.pc_addr, 32'h8);
        chk("fault_prior_deliv", n_deliv - d0, 2);
        repeat (10) tick();
        chk("halt_hold", fault, 1);
        chk("halt_no_issue", mosi.rd_addr_valid, 0);
        chk("halt_pc", trap.pc_addr, 32'h8);
        fault_addr = '1;
        raise_req(32'h40);
        chk("fault_cleared", fault, 0);
        wait_deliv("fault_resume", 4, 30);

        // Reset with reads in flight; stale replies must be ignored.
        reset_dut();
        lat_min = 6;
        lat_max = 6;
        raise_start(32'h400);
        repeat (3) tick();
        rst   = 1'b1;
        start = 1'b0;
        #1;
        chk_reset("rst_mid");
        repeat (2) tick();
        rst = 1'b0;
        lat_min = 0;
        lat_max = 0;
        repeat (15) tick();
        chk("post_rst_valid", valid, 0);
        chk("post_rst_no_req", mosi.rd_addr_valid, 0);
        raise_start(32'h500);
        wait_deliv("post_rst_deliv", 5, 40);

        // Random latency, back-pressure, redirects and faults.
        reset_dut();
        rand_faults = 1;
        lat_min     = 0;
        lat_max     = 3;
        ardy_pct    = 75;
        d0          = n_deliv;
        raise_start(32'($urandom_range(0, 127)) << 2);
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                raise_req(32'($urandom_range(0, 127)) << 2);
                tick();
            end else begin
                tick();
            end
        end
        chk("rand_progress", 32'(n_deliv - d0 > 100), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
